// File: rtl/renas_ahb_arbiter.sv
// N-master AHB-lite arbiter with address/data-phase multiplexing.
// Ownership is held across defined-length bursts, undefined INCR bursts and locked sequences.
module renas_ahb_arbiter #(
    parameter int NUM_MASTER = 3,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int PRIOR_W    = 2,
    parameter int RR_MODE    = 0
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic [2*NUM_MASTER-1:0]       m_htrans,
    input  logic [ADDR_W*NUM_MASTER-1:0]  m_haddr,
    input  logic [NUM_MASTER-1:0]         m_hwrite,
    input  logic [NUM_MASTER-1:0]         m_hmastlock,
    input  logic [3*NUM_MASTER-1:0]       m_hsize,
    input  logic [3*NUM_MASTER-1:0]       m_hburst,
    input  logic [DATA_W*NUM_MASTER-1:0]  m_hwdata,
    input  logic [PRIOR_W*NUM_MASTER-1:0] m_hprior,
    output logic [NUM_MASTER-1:0]         m_hready,
    output logic [NUM_MASTER-1:0]         m_hresp,
    output logic [DATA_W-1:0]             hrdata_bcast,
    output logic [1:0]                    s_htrans,
    output logic [ADDR_W-1:0]             s_haddr,
    output logic                          s_hwrite,
    output logic [2:0]                    s_hsize,
    output logic [2:0]                    s_hburst,
    output logic                          s_hmastlock,
    output logic [DATA_W-1:0]             s_hwdata,
    input  logic                          s_hready,
    input  logic                          s_hresp,
    input  logic [DATA_W-1:0]             s_hrdata,
    output logic [$clog2(NUM_MASTER)-1:0] hmaster,
    output logic [NUM_MASTER-1:0]         hgrant
);
    localparam int IDX_W = $clog2(NUM_MASTER);
    typedef logic [IDX_W-1:0] idx_t;

    logic [1:0]         trans_a [NUM_MASTER];
    logic [ADDR_W-1:0]  addr_a  [NUM_MASTER];
    logic [2:0]         size_a  [NUM_MASTER];
    logic [2:0]         burst_a [NUM_MASTER];
    logic [DATA_W-1:0]  wdata_a [NUM_MASTER];
    logic [PRIOR_W-1:0] prior_a [NUM_MASTER];

    idx_t         aown;
    idx_t         down;
    logic         dval;
    logic [3:0]   beat_cnt;
    logic         incr_act;
    idx_t         rr_ptr;

    logic [3:0]   beat_nxt;
    logic         incr_nxt;
    logic         arb_pt;
    logic         any_req;
    logic [PRIOR_W-1:0] max_prior;
    idx_t         win;
    logic [1:0]   own_trans;
    logic [2:0]   own_burst;

    function automatic logic [3:0] burst_len(input logic [2:0] burst);
        case (burst)
            3'b010, 3'b011: burst_len = 4'd3;
            3'b100, 3'b101: burst_len = 4'd7;
            3'b110, 3'b111: burst_len = 4'd15;
            default:        burst_len = 4'd0;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_MASTER; i++) begin
            trans_a[i] = m_htrans[2*i +: 2];
            addr_a[i]  = m_haddr[ADDR_W*i +: ADDR_W];
            size_a[i]  = m_hsize[3*i +: 3];
            burst_a[i] = m_hburst[3*i +: 3];
            wdata_a[i] = m_hwdata[DATA_W*i +: DATA_W];
            prior_a[i] = m_hprior[PRIOR_W*i +: PRIOR_W];
        end
    end

    assign own_trans    = trans_a[aown];
    assign own_burst    = burst_a[aown];
    assign s_htrans     = own_trans;
    assign s_haddr      = addr_a[aown];
    assign s_hwrite     = m_hwrite[aown];
    assign s_hsize      = size_a[aown];
    assign s_hburst     = own_burst;
    assign s_hmastlock  = m_hmastlock[aown];
    assign s_hwdata     = wdata_a[down];
    assign hrdata_bcast = s_hrdata;
    assign hmaster      = aown;

    // Burst tracking uses the post-update count so the final beat and the handover share a cycle.
    always_comb begin
        beat_nxt = beat_cnt;
        incr_nxt = incr_act;
        if (s_hready) begin
            case (own_trans)
                2'b10: begin
                    beat_nxt = burst_len(own_burst);
                    incr_nxt = (own_burst == 3'b001);
                end
                2'b11: begin
                    if (beat_cnt != 4'd0)
                        beat_nxt = beat_cnt - 4'd1;
                end
                2'b00: incr_nxt = 1'b0;
                default: ;
            endcase
        end else if (dval && s_hresp) begin
            beat_nxt = 4'd0;
            incr_nxt = 1'b0;
        end
    end

    assign arb_pt = s_hready && (beat_nxt == 4'd0) && !m_hmastlock[aown] && !incr_nxt;

    // Scan order starts after the last grant in round-robin mode, at index 0 otherwise.
    always_comb begin
        int idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        any_req   = 1'b0;
        max_prior = '0;
        win       = aown;
        for (int i = 0; i < NUM_MASTER; i++) begin
            if (trans_a[i][1] && (!any_req || prior_a[i] > max_prior)) begin
                any_req   = 1'b1;
                max_prior = prior_a[i];
            end
        end
        for (int k = 1; k <= NUM_MASTER; k++) begin
            idx = (RR_MODE != 0) ? int'(rr_ptr) + k : k - 1;
            if (idx >= NUM_MASTER)
                idx = idx - NUM_MASTER;
            if (!found && trans_a[idx][1] && prior_a[idx] == max_prior) begin
                win   = idx_t'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            aown     <= '0;
            down     <= '0;
            dval     <= 1'b0;
            beat_cnt <= '0;
            incr_act <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            beat_cnt <= beat_nxt;
            incr_act <= incr_nxt;
            if (s_hready) begin
                down <= aown;
                dval <= s_htrans[1];
            end
            if (arb_pt) begin
                aown <= win;
                if (any_req)
                    rr_ptr <= win;
            end
        end
    end

    always_comb begin
        m_hready = '0;
        m_hresp  = '0;
        hgrant   = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            hgrant[i]   = (idx_t'(i) == aown);
            m_hready[i] = s_hready && ((idx_t'(i) == aown) || (dval && idx_t'(i) == down));
            m_hresp[i]  = s_hresp && dval && (idx_t'(i) == down);
        end
    end
endmodule

// File: tb/tb_renas_ahb_arbiter.sv
// Bench for renas_ahb_arbiter: fixed-priority and round-robin instances share stimulus
// and are compared every cycle against a transaction-level ownership model.
module tb_renas_ahb_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          hreset;
    logic [1:0]    tr [N];
    logic [AW-1:0] ad [N];
    logic [2:0]    sz [N];
    logic [2:0]    bu [N];
    logic [DW-1:0] wd [N];
    logic [PW-1:0] pr [N];
    logic [N-1:0]  wr, lk;
    logic          s_hready, s_hresp;
    logic [DW-1:0] s_hrdata;

    logic [2*N-1:0]  m_htrans;
    logic [AW*N-1:0] m_haddr;
    logic [3*N-1:0]  m_hsize, m_hburst;
    logic [DW*N-1:0] m_hwdata;
    logic [PW*N-1:0] m_hprior;

    always_comb begin
        m_htrans = '0; m_haddr = '0; m_hsize = '0; m_hburst = '0; m_hwdata = '0; m_hprior = '0;
        for (int i = 0; i < N; i++) begin
            m_htrans[2*i +: 2]   = tr[i];
            m_haddr[AW*i +: AW]  = ad[i];
            m_hsize[3*i +: 3]    = sz[i];
            m_hburst[3*i +: 3]   = bu[i];
            m_hwdata[DW*i +: DW] = wd[i];
            m_hprior[PW*i +: PW] = pr[i];
        end
    end

    logic [N-1:0]  fp_m_hready, fp_m_hresp, fp_hgrant, rr_m_hready, rr_m_hresp, rr_hgrant;
    logic [DW-1:0] fp_hrdata, fp_s_hwdata, rr_hrdata, rr_s_hwdata;
    logic [1:0]    fp_s_htrans, rr_s_htrans, fp_hmaster, rr_hmaster;
    logic [AW-1:0] fp_s_haddr, rr_s_haddr;
    logic          fp_s_hwrite, fp_s_hmastlock, rr_s_hwrite, rr_s_hmastlock;
    logic [2:0]    fp_s_hsize, fp_s_hburst, rr_s_hsize, rr_s_hburst;

    renas_ahb_arbiter #(.NUM_MASTER(N), .ADDR_W(AW), .DATA_W(DW), .PRIOR_W(PW), .RR_MODE(0)) dut_fp (
        .hclk(clk), .hreset(hreset),
        .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(wr), .m_hmastlock(lk),
        .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata), .m_hprior(m_hprior),
        .m_hready(fp_m_hready), .m_hresp(fp_m_hresp), .hrdata_bcast(fp_hrdata),
        .s_htrans(fp_s_htrans), .s_haddr(fp_s_haddr), .s_hwrite(fp_s_hwrite),
        .s_hsize(fp_s_hsize), .s_hburst(fp_s_hburst), .s_hmastlock(fp_s_hmastlock),
        .s_hwdata(fp_s_hwdata), .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
        .hmaster(fp_hmaster), .hgrant(fp_hgrant));

    renas_ahb_arbiter #(.NUM_MASTER(N), .ADDR_W(AW), .DATA_W(DW), .PRIOR_W(PW), .RR_MODE(1)) dut_rr (
        .hclk(clk), .hreset(hreset),
        .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(wr), .m_hmastlock(lk),
        .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata), .m_hprior(m_hprior),
        .m_hready(rr_m_hready), .m_hresp(rr_m_hresp), .hrdata_bcast(rr_hrdata),
        .s_htrans(rr_s_htrans), .s_haddr(rr_s_haddr), .s_hwrite(rr_s_hwrite),
        .s_hsize(rr_s_hsize), .s_hburst(rr_s_hburst), .s_hmastlock(rr_s_hmastlock),
        .s_hwdata(rr_s_hwdata), .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
        .hmaster(rr_hmaster), .hgrant(rr_hgrant));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state per instance: index 0 fixed priority, 1 round-robin.
    int mo_aown [2];
    int mo_down [2];
    int mo_left [2];
    int mo_ptr  [2];
    bit mo_dval [2];
    bit mo_incr [2];

    function automatic int burst_beats(input logic [2:0] b);
        return (b < 3'd2) ? 1 : (2 << (b >> 1));
    endfunction

    task automatic model_step(input int m);
        int own, best, bestp, bestd, d;
        if (hreset) begin
            mo_aown[m] = 0; mo_down[m] = 0; mo_left[m] = 0; mo_ptr[m] = 0;
            mo_dval[m] = 1'b0; mo_incr[m] = 1'b0;
        end else if (!s_hready) begin
            if (mo_dval[m] && s_hresp) begin
                mo_left[m] = 0;
                mo_incr[m] = 1'b0;
            end
        end else begin
            own = mo_aown[m];
            if (tr[own] == 2'b10) begin
                mo_left[m] = burst_beats(bu[own]) - 1;
                mo_incr[m] = (bu[own] == 3'b001);
            end else if (tr[own] == 2'b11) begin
                if (mo_left[m] > 0) mo_left[m] = mo_left[m] - 1;
            end else if (tr[own] == 2'b00) begin
                mo_incr[m] = 1'b0;
            end
            mo_down[m] = own;
            mo_dval[m] = tr[own][1];
            if (mo_left[m] == 0 && !mo_incr[m] && !lk[own]) begin
                best = -1; bestp = -1; bestd = N + 1;
                for (int i = 0; i < N; i++) begin
                    if (tr[i][1]) begin
                        d = (m == 0) ? i : (i - mo_ptr[m] - 1 + 2*N) % N;
                        if (int'(pr[i]) > bestp || (int'(pr[i]) == bestp && d < bestd)) begin
                            best = i; bestp = int'(pr[i]); bestd = d;
                        end
                    end
                end
                if (best >= 0) begin
                    mo_aown[m] = best;
                    mo_ptr[m]  = best;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step(0);
        model_step(1);
        if (hreset) chk_en = 1'b1;
    end

    task automatic cmp_mode(input int m, input logic [1:0] hm, input logic [N-1:0] gr,
                            input logic [N-1:0] rdy, input logic [N-1:0] rsp,
                            input logic [AW-1:0] a, input logic [1:0] t, input logic [7:0] ctl,
                            input logic [DW-1:0] wdat, input logic [DW-1:0] rdat);
        int own;
        logic [N-1:0] e_rdy, e_rsp;
        own = mo_aown[m];
        for (int i = 0; i < N; i++) begin
            e_rdy[i] = s_hready && (i == own || (mo_dval[m] && i == mo_down[m]));
            e_rsp[i] = s_hresp && mo_dval[m] && i == mo_down[m];
        end
        chk($sformatf("m%0d_hmaster", m), hm, own);
        chk($sformatf("m%0d_hgrant", m), gr, 1 << own);
        chk($sformatf("m%0d_m_hready", m), rdy, e_rdy);
        chk($sformatf("m%0d_m_hresp", m), rsp, e_rsp);
        chk($sformatf("m%0d_s_haddr", m), a, ad[own]);
        chk($sformatf("m%0d_s_htrans", m), t, tr[own]);
        chk($sformatf("m%0d_s_ctrl", m), ctl, {wr[own], sz[own], bu[own], lk[own]});
        chk($sformatf("m%0d_s_hwdata", m), wdat, wd[mo_down[m]]);
        chk($sformatf("m%0d_hrdata", m), rdat, s_hrdata);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp_mode(0, fp_hmaster, fp_hgrant, fp_m_hready, fp_m_hresp, fp_s_haddr, fp_s_htrans,
                     {fp_s_hwrite, fp_s_hsize, fp_s_hburst, fp_s_hmastlock}, fp_s_hwdata, fp_hrdata);
            cmp_mode(1, rr_hmaster, rr_hgrant, rr_m_hready, rr_m_hresp, rr_s_haddr, rr_s_htrans,
                     {rr_s_hwrite, rr_s_hsize, rr_s_hburst, rr_s_hmastlock}, rr_s_hwdata, rr_hrdata);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            tr[i] = 2'b00; ad[i] = '0; sz[i] = 3'd2; bu[i] = 3'd0; wd[i] = '0; pr[i] = '0;
        end
        wr = '0;
        lk = '0;
    endtask

    initial begin
        hreset = 1'b1; s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
        idle_all();
        next(); next();
        hreset = 1'b0;
        mid();
        chk("rst_hgrant", fp_hgrant, 3'b001);
        chk("rst_hmaster", fp_hmaster, 0);
        chk("rst_m_hready", fp_m_hready, 3'b001);
        chk("rst_m_hresp", fp_m_hresp, 0);

        // single read by master 1
        next(); tr[1] = 2'b10; ad[1] = 32'h1000;
        mid(); chk("a_pre_hmaster", fp_hmaster, 0);
        next();
        mid(); chk("a_hmaster", fp_hmaster, 1); chk("a_haddr", fp_s_haddr, 32'h1000);
        next(); tr[1] = 2'b00; s_hready = 1'b0;
        mid(); chk("a_stall_hready", fp_m_hready, 3'b000);
        next(); s_hready = 1'b1; s_hrdata = 32'hCAFE0001;
        mid(); chk("a_data_hready", fp_m_hready, 3'b010); chk("a_hrdata", fp_hrdata, 32'hCAFE0001);

        // priority: master 2 (INCR) beats master 0, then master 0 after IDLE
        next();
        tr[0] = 2'b10; ad[0] = 32'h2000; pr[0] = 2'd1;
        tr[2] = 2'b10; ad[2] = 32'h3000; bu[2] = 3'b001; pr[2] = 2'd3;
        mid(); chk("b_arb_hmaster", fp_hmaster, 1);
        next();
        mid(); chk("b_grant2", fp_hmaster, 2); chk("b_hready", fp_m_hready, 3'b100);
        next(); tr[2] = 2'b11; ad[2] = 32'h3004;
        mid(); chk("b_incr_hold1", fp_hmaster, 2); chk("b_m0_stall1", fp_m_hready[0], 0);
        next(); ad[2] = 32'h3008;
        mid(); chk("b_incr_hold2", fp_hmaster, 2); chk("b_m0_stall2", fp_m_hready[0], 0);
        next(); tr[2] = 2'b00;
        mid(); chk("b_idle_hmaster", fp_hmaster, 2);
        next();
        mid(); chk("b_grant0", fp_hmaster, 0); chk("b_haddr0", fp_s_haddr, 32'h2000);

        // INCR4 by master 0 is not interrupted by higher-priority master 1
        next(); tr[0] = 2'b10; ad[0] = 32'h4000; bu[0] = 3'b011; pr[0] = 2'd0; pr[2] = 2'd0;
        mid(); chk("c_beat1", fp_hmaster, 0);
        next(); tr[0] = 2'b11; ad[0] = 32'h4004; tr[1] = 2'b10; ad[1] = 32'h5000; pr[1] = 2'd2;
        mid(); chk("c_beat2", fp_hmaster, 0);
        next(); ad[0] = 32'h4008;
        mid(); chk("c_beat3", fp_hmaster, 0);
        next(); ad[0] = 32'h400C;
        mid(); chk("c_beat4", fp_hmaster, 0);
        next(); tr[0] = 2'b00; bu[0] = 3'd0;
        mid(); chk("c_grant1", fp_hmaster, 1); chk("c_haddr1", fp_s_haddr, 32'h5000);

        // write by master 2 with wait states, then ERROR
        next(); tr[1] = 2'b00; pr[1] = 2'd0;
        tr[2] = 2'b10; ad[2] = 32'h6000; bu[2] = 3'd0; wr[2] = 1'b1; wd[2] = 32'hD00D0002;
        mid();
        next();
        mid(); chk("e_hmaster", fp_hmaster, 2);
        next(); tr[2] = 2'b00; wd[1] = 32'h11111111;
        tr[0] = 2'b10; ad[0] = 32'h8000; pr[0] = 2'd3; s_hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) next();
            mid();
            chk("e_wait_hwdata", fp_s_hwdata, 32'hD00D0002);
            chk("e_wait_hmaster", fp_hmaster, 2);
            chk("e_wait_hready", fp_m_hready, 3'b000);
        end
        next(); s_hresp = 1'b1;
        mid(); chk("e_err1_hresp", fp_m_hresp, 3'b100); chk("e_err1_hready", fp_m_hready, 3'b000);
        next(); s_hready = 1'b1;
        mid(); chk("e_err2_hresp", fp_m_hresp, 3'b100); chk("e_err2_hready", fp_m_hready, 3'b100);
        next(); s_hresp = 1'b0; wr[2] = 1'b0;
        mid(); chk("e_grant0", fp_hmaster, 0);

        // reset in the middle of an INCR8 burst
        next(); tr[0] = 2'b00; pr[0] = 2'd0; tr[1] = 2'b10; ad[1] = 32'h7000; bu[1] = 3'b101;
        mid();
        next();
        mid(); chk("f_beat1", fp_hmaster, 1);
        for (int b = 2; b <= 5; b++) begin
            next(); tr[1] = 2'b11; ad[1] = 32'h7000 + 32'(4 * (b - 1));
            if (b == 5) hreset = 1'b1;
            mid(); chk("f_beat_hmaster", fp_hmaster, 1);
        end
        next(); hreset = 1'b0; tr[1] = 2'b00; bu[1] = 3'd0; tr[2] = 2'b10; ad[2] = 32'h9000;
        mid();
        chk("f_rst_hgrant", fp_hgrant, 3'b001);
        chk("f_rst_hready", fp_m_hready, 3'b001);
        chk("f_rst_hmaster", fp_hmaster, 0);
        next(); tr[2] = 2'b00;
        mid(); chk("f_cnt_cleared", fp_hmaster, 2);

        // round-robin among three equal-priority continuous requesters
        next(); hreset = 1'b1; idle_all();
        next(); hreset = 1'b0;
        for (int i = 0; i < N; i++) begin
            tr[i] = 2'b10; ad[i] = 32'hA000 + 32'(i * 16'h100);
        end
        mid(); chk("d_rr_start", rr_hmaster, 0);
        for (int k = 1; k <= 6; k++) begin
            next();
            mid();
            chk("d_rr_order", rr_hmaster, k % 3);
            chk("d_fp_stays0", fp_hmaster, 0);
        end

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            next();
            hreset   = ($urandom_range(0, 299) == 0);
            s_hready = ($urandom_range(0, 3) != 0);
            s_hresp  = ($urandom_range(0, 15) == 0);
            s_hrdata = $urandom;
            for (int i = 0; i < N; i++) begin
                tr[i] = 2'($urandom_range(0, 3));
                ad[i] = $urandom;
                sz[i] = 3'($urandom_range(0, 2));
                bu[i] = 3'($urandom_range(0, 7));
                wd[i] = $urandom;
                wr[i] = 1'($urandom_range(0, 1));
                lk[i] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 15) == 0) pr[i] = PW'($urandom_range(0, 3));
            end
        end
        next();
        mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
